spi_mem_bridge: RTL and testbench

SPI_MEM_BRIDGE -- requirements
Module: spi_mem_bridge

---
 rtl/spi_bridge_pkg.sv | 28 ++
 rtl/sat_counter.sv | 15 +
 rtl/spi_mem_bridge.sv | 125 ++++++++++++
 tb/tb_spi_mem_bridge.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_bridge_pkg.sv
// spi_bridge_pkg: shared opcodes, field widths and FSM states for the SPI memory bridge
// Contents: op_e (packet opcodes), state_e (bridge FSM), OP_W (opcode field width),
//   CNT_W (diagnostic counter width).
package spi_bridge_pkg;

    localparam int OP_W  = 4;
    localparam int CNT_W = 8;

    typedef enum logic [OP_W-1:0] {
        OP_NOP        = 4'h0,
        OP_WRITE      = 4'h1,
        OP_READ       = 4'h2,
        OP_WRITE_NEXT = 4'h3,
        OP_READ_NEXT  = 4'h4,
        OP_STATUS     = 4'h5,
        OP_INVALID    = 4'hF
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ_ISSUE,
        S_READ_WAIT,
        S_STATUS,
        S_LOAD
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that holds at its maximum instead of wrapping
// Ports: clk; clr (synchronous clear, wins over inc); inc (count enable); count (value).
module sat_counter
    import spi_bridge_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk)
        count <= clr ? '0 : (inc && count != '1) ? count + 1'b1 : count;

endmodule

// File: rtl/spi_mem_bridge.sv
// spi_mem_bridge: decodes SPI command packets into parameter-memory accesses and responses
// Ports: clk; reset (synchronous, active high); packet/packet_valid from the SPI serdes;
//   response/response_load back to the serdes; mem_addr/mem_wdata/mem_we/mem_rdata to a
//   memory with one-cycle read latency; err_count/ovr_count saturating diagnostics.
// Build option: SPI_BRIDGE_AUTOINC_EN adds WRITE_NEXT/READ_NEXT through an address pointer;
//   without it those opcodes are rejected as invalid.
module spi_mem_bridge
    import spi_bridge_pkg::*;
#(
    parameter  int ADDR_WIDTH   = 12,
    parameter  int DATA_WIDTH   = 24,
    localparam int PACKET_WIDTH = OP_W + ADDR_WIDTH + DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PACKET_WIDTH-1:0] packet,
    input  logic                    packet_valid,
    output logic [PACKET_WIDTH-1:0] response,
    output logic                    response_load,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic                    mem_we,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic [CNT_W-1:0]        err_count,
    output logic [CNT_W-1:0]        ovr_count
);

    state_e                state, state_nxt;
    logic [OP_W-1:0]       op_in, op_q;
    logic [ADDR_WIDTH-1:0] addr_in, eff_addr;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  is_write, is_read, is_status, is_nop, is_bad;
    logic                  accept, overrun;

    assign op_in   = packet[PACKET_WIDTH-1 -: OP_W];
    assign addr_in = packet[DATA_WIDTH +: ADDR_WIDTH];
    assign data_in = packet[DATA_WIDTH-1:0];

    // Reset priority lives in the registers and counters, so these need no reset term.
    assign accept  = packet_valid && state == S_IDLE;
    assign overrun = packet_valid && state != S_IDLE;

    assign is_status = op_in == OP_STATUS;
    assign is_nop    = op_in == OP_NOP;
    assign is_bad    = !(is_write || is_read || is_status || is_nop);

`ifdef SPI_BRIDGE_AUTOINC_EN
    logic [ADDR_WIDTH-1:0] addr_ptr;
    logic                  use_ptr;

    assign use_ptr  = op_in == OP_WRITE_NEXT || op_in == OP_READ_NEXT;
    assign is_write = op_in == OP_WRITE || op_in == OP_WRITE_NEXT;
    assign is_read  = op_in == OP_READ || op_in == OP_READ_NEXT;
    assign eff_addr = use_ptr ? addr_ptr : addr_in;

    // Every access, explicit or pointer-based, leaves the pointer one past the address used.
    always_ff @(posedge clk)
        addr_ptr <= reset ? '0 : (accept && (is_write || is_read)) ? eff_addr + 1'b1 : addr_ptr;
`else
    assign is_write = op_in == OP_WRITE;
    assign is_read  = op_in == OP_READ;
    assign eff_addr = addr_in;
`endif

    always_ff @(posedge clk)
        state <= reset ? S_IDLE : state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:       state_nxt = !accept   ? S_IDLE :
                                      is_write  ? S_WRITE :
                                      is_read   ? S_READ_ISSUE :
                                      is_status ? S_STATUS :
                                      is_bad    ? S_LOAD : S_IDLE;
            S_WRITE:      state_nxt = S_LOAD;
            S_READ_ISSUE: state_nxt = S_READ_WAIT;
            S_READ_WAIT:  state_nxt = S_LOAD;
            S_STATUS:     state_nxt = S_LOAD;
            S_LOAD:       state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    // Strobes are gated by reset so nothing escapes in a cycle where reset is asserted.
    always_comb begin
        mem_we        = state == S_WRITE && !reset;
        response_load = state == S_LOAD && !reset;
    end

    // response only changes on the edge entering S_LOAD, so it moves together with the strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            response  <= '0;
        end else begin
            op_q      <= (accept && (is_write || is_read)) ? op_in : op_q;
            mem_addr  <= (accept && (is_write || is_read)) ? eff_addr : mem_addr;
            mem_wdata <= (accept && is_write) ? data_in : mem_wdata;
            response  <= (accept && is_bad)      ? {OP_INVALID, addr_in, {DATA_WIDTH{1'b0}}} :
                         (state == S_WRITE)      ? {op_q, mem_addr, mem_wdata} :
                         (state == S_READ_WAIT)  ? {op_q, mem_addr, mem_rdata} :
                         (state == S_STATUS)     ? {OP_STATUS, {ADDR_WIDTH{1'b0}},
                                                    DATA_WIDTH'({8'h00, err_count, ovr_count})} :
                                                   response;
        end
    end

    sat_counter u_err (
        .clk   (clk),
        .clr   (reset),
        .inc   (accept && is_bad),
        .count (err_count)
    );

    sat_counter u_ovr (
        .clk   (clk),
        .clr   (reset),
        .inc   (overrun),
        .count (ovr_count)
    );

endmodule

// File: tb/tb_spi_mem_bridge.sv
// tb_spi_mem_bridge: scoreboard bench for spi_mem_bridge with a behavioural command model
module tb_spi_mem_bridge;

    localparam int AW = 12;
    localparam int DW = 24;
    localparam int PW = 40;
`ifdef SPI_BRIDGE_AUTOINC_EN
    localparam bit AI = 1'b1;
`else
    localparam bit AI = 1'b0;
`endif

    typedef struct {
        logic [PW-1:0] v;
        int            c;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          packet_valid = 1'b0;
    logic [PW-1:0] packet = '0;
    logic [PW-1:0] response;
    logic          response_load;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_we;
    logic [7:0]    err_count;
    logic [7:0]    ovr_count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    exp_t rq[$];
    exp_t wq[$];
    exp_t me;

    logic [DW-1:0] mem [4096];
    bit            wr  [4096];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    int            m_err = 0;
    int            m_ovr = 0;
    int            free_t = 0;
    logic [AW-1:0] m_ptr = '0;
    logic [PW-1:0] prev_resp = '0;
    logic          was_rst = 1'b1;

    spi_mem_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .reset         (reset),
        .packet        (packet),
        .packet_valid  (packet_valid),
        .response      (response),
        .response_load (response_load),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .mem_rdata     (mem_rdata),
        .err_count     (err_count),
        .ovr_count     (ovr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: never-written words read back as {addr, ~addr}.
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wr[mem_addr]  <= 1'b1;
        end
        mem_rdata <= wr[mem_addr] ? mem[mem_addr] : {mem_addr, ~mem_addr};
    end

    task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int sat(input int v);
        return v > 255 ? 255 : v;
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : {a, ~a};
    endfunction

    // Command model: a packet offered while a previous command is still being served is an
    // overrun; otherwise it is executed and its expected memory write / response are queued.
    task automatic model(input logic [3:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d, input int t);
        logic [AW-1:0] ea;
        if (t < free_t) begin
            m_ovr = sat(m_ovr + 1);
            return;
        end
        ea = (AI && (op == 4'h3 || op == 4'h4)) ? m_ptr : a;
        if (op == 4'h0) begin
            free_t = t + 1;
        end else if (op == 4'h1 || (AI && op == 4'h3)) begin
            wq.push_back('{{4'h0, ea, d}, t + 1});
            ref_mem[ea] = d;
            rq.push_back('{{op, ea, d}, -1});
            m_ptr = ea + 1'b1;
            free_t = t + 3;
        end else if (op == 4'h2 || (AI && op == 4'h4)) begin
            rq.push_back('{{op, ea, ref_rd(ea)}, t + 3});
            m_ptr = ea + 1'b1;
            free_t = t + 4;
        end else if (op == 4'h5) begin
            rq.push_back('{{4'h5, 12'h000, 8'h00, 8'(m_err), 8'(m_ovr)}, -1});
            free_t = t + 3;
        end else begin
            m_err = sat(m_err + 1);
            rq.push_back('{{4'hF, a, 24'h000000}, -1});
            free_t = t + 2;
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d, input int gap);
        model(op, a, d, cyc);
        packet = {op, a, d};
        packet_valid = 1'b1;
        wait_cycles(1);
        packet_valid = 1'b0;
        wait_cycles(gap - 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((rq.size() != 0 || wq.size() != 0) && n < 200) begin
            wait_cycles(1);
            n++;
        end
        wait_cycles(6);
        chk("drain_resp_queue", 40'(rq.size()), 40'd0);
        chk("drain_write_queue", 40'(wq.size()), 40'd0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_response"}, response, 40'd0);
        chk({tag, "_response_load"}, 40'(response_load), 40'd0);
        chk({tag, "_mem_we"}, 40'(mem_we), 40'd0);
        chk({tag, "_mem_addr"}, 40'(mem_addr), 40'd0);
        chk({tag, "_mem_wdata"}, 40'(mem_wdata), 40'd0);
        chk({tag, "_err_count"}, 40'(err_count), 40'd0);
        chk({tag, "_ovr_count"}, 40'(ovr_count), 40'd0);
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (response_load) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected: got %h at cycle %0d, expected no response", response, cyc);
            end else begin
                me = rq.pop_front();
                chk("resp", response, me.v);
                if (me.c >= 0) chk("resp_cycle", 40'(cyc), 40'(me.c));
            end
        end
        if (mem_we) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL write_unexpected: got addr %h data %h at cycle %0d, expected no write", mem_addr, mem_wdata, cyc);
            end else begin
                me = wq.pop_front();
                chk("write", {4'h0, mem_addr, mem_wdata}, me.v);
                chk("write_cycle", 40'(cyc), 40'(me.c));
            end
        end
        if (response !== prev_resp) begin
            checks++;
            if (!response_load && !was_rst) begin
                errors++;
                $display("FAIL resp_stable: got %h without response_load, expected %h held", response, prev_resp);
            end
        end
        prev_resp = response;
        was_rst = reset;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        wait_cycles(3);
        chk_outputs_zero("reset");
        reset = 1'b0;
        wait_cycles(2);

        send(4'h1, 12'h123, 24'hABCDEF, 6);
        send(4'h1, 12'h010, 24'h00BEEF, 6);
        send(4'h2, 12'h010, 24'h000000, 6);
        send(4'h2, 12'h011, 24'h000000, 1);
        send(4'h1, 12'h012, 24'h555555, 6);
        drain();
        chk("overrun_count", 40'(ovr_count), 40'd1);

        send(4'h1, 12'hFFF, 24'h000011, 6);
        send(4'h3, 12'h0AB, 24'h000077, 6);
        drain();
        chk("autoinc_err_count", 40'(err_count), 40'(AI ? 0 : 1));

        for (int i = 0; i < 300; i++)
            send(4'($urandom_range(0, 15)), 12'($urandom_range(0, 31)), 24'($urandom), $urandom_range(1, 5));
        drain();
        chk("random_err_count", 40'(err_count), 40'(m_err));
        chk("random_ovr_count", 40'(ovr_count), 40'(m_ovr));

        packet = {4'h2, 12'h005, 24'h000000};
        packet_valid = 1'b1;
        wait_cycles(1);
        packet_valid = 1'b0;
        wait_cycles(1);
        reset = 1'b1;
        packet = {4'h9, 12'h000, 24'h000000};
        packet_valid = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        packet_valid = 1'b0;
        m_err = 0;
        m_ovr = 0;
        m_ptr = '0;
        wait_cycles(5);
        chk_outputs_zero("abort");

        for (int i = 0; i < 260; i++)
            send(4'h9, 12'($urandom), 24'($urandom), 2);
        drain();
        chk("err_saturated", 40'(err_count), 40'd255);
        send(4'h5, 12'h000, 24'h000000, 4);
        drain();

        for (int i = 0; i < 90; i++) begin
            send(4'h2, 12'($urandom_range(0, 31)), 24'h000000, 1);
            repeat (3) send(4'h0, 12'h000, 24'h000000, 1);
        end
        drain();
        chk("ovr_saturated", 40'(ovr_count), 40'd255);
        send(4'h5, 12'h000, 24'h000000, 4);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
